// File: rtl/q8_pkg.sv
// Shared types and constants for the 1011 serial pattern detector.
// Holds the state encoding and the pattern value.
package q8_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } seq_state_t;

  localparam logic [3:0] PATTERN = 4'b1011;

  function automatic seq_state_t next_state(
    input seq_state_t s,
    input logic       b
  );
    seq_state_t n;
    n = IDLE;
    unique case (s)
      IDLE:    n = b ? S1    : IDLE;
      S1:      n = b ? S1    : S10;
      S10:     n = b ? S101  : IDLE;
      S101:    n = b ? S1011 : S10;
      S1011:   n = b ? S1    : S10;
      default: n = IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating match counter with a sticky overflow flag.
// Overflow latches when an increment arrives at full scale.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (inc) begin
      if (count == MAX) overflow <= 1'b1;
      else              count    <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_1011.sv
// Moore detector for serial pattern 1,0,1,1 with overlap.
// Counts matches through a saturating counter.
module seq_detect_1011
  import q8_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             en,
  output logic             match,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  seq_state_t state;
  logic       hit;

  // hit marks the edge that enters S1011
  assign hit   = en && (next_state(state, din) == S1011);
  assign match = (state == S1011);

  always_ff @(posedge clk) begin
    if (reset)   state <= IDLE;
    else if (en) state <= next_state(state, din);
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc     (hit),
    .count   (count),
    .overflow(overflow)
  );

endmodule

// File: tb/tb_seq_detect_1011.sv
// Directed bench for seq_detect_1011 at CNT_W=8 and CNT_W=2.
// Includes an upstream flop driving din.
module tb_seq_detect_1011;

  logic       clk = 1'b0;
  logic       reset;
  logic       din_drv;
  logic       en;
  logic       use_ms;
  logic       ms_d;
  logic       ms_q;
  logic       din;
  logic       match_a, ovf_a;
  logic [7:0] count_a;
  logic       match_b, ovf_b;
  logic [1:0] count_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) ms_q <= ms_d;

  assign din = use_ms ? ms_q : din_drv;

  seq_detect_1011 #(.CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .din(din), .en(en),
    .match(match_a), .count(count_a), .overflow(ovf_a)
  );

  seq_detect_1011 #(.CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .din(din), .en(en),
    .match(match_b), .count(count_b), .overflow(ovf_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic b, input logic e);
    din_drv = b;
    en      = e;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ms_d  = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; din_drv = 1'b0; en = 1'b0;
    use_ms = 1'b0; ms_d = 1'b0;

    // basic match
    do_reset();
    chk("rst_match", match_a, 0);
    chk("rst_count", count_a, 0);
    chk("rst_ovf", ovf_a, 0);
    tick(1, 1); tick(0, 1); tick(1, 1);
    chk("pre_match", match_a, 0);
    tick(1, 1);
    chk("basic_match", match_a, 1);
    chk("basic_count", count_a, 1);

    // overlapping 1011011
    tick(0, 1);
    chk("ovl_gap1", match_a, 0);
    tick(1, 1);
    chk("ovl_gap2", match_a, 0);
    tick(1, 1);
    chk("ovl_match2", match_a, 1);
    chk("ovl_count", count_a, 2);

    // en=0 hold with din toggling
    do_reset();
    tick(1, 1); tick(0, 1); tick(1, 1);
    for (int i = 0; i < 5; i++) tick(logic'(i[0]), 0);
    chk("hold_match", match_a, 0);
    chk("hold_count", count_a, 0);
    tick(1, 1);
    chk("hold_hit", match_a, 1);
    chk("hold_hit_cnt", count_a, 1);
    tick(0, 0); tick(1, 0);
    chk("hold_s1011", match_a, 1);
    chk("hold_s1011_cnt", count_a, 1);
    tick(0, 1);
    chk("leave_s1011", match_a, 0);

    // saturation on the narrow instance
    do_reset();
    tick(1, 1); tick(0, 1); tick(1, 1); tick(1, 1);
    chk("sat_c1", count_b, 1);
    for (int k = 2; k <= 5; k++) begin
      tick(0, 1); tick(1, 1); tick(1, 1);
      chk("sat_match", match_b, 1);
      chk("sat_count", count_b, k > 3 ? 3 : k);
      chk("sat_ovf", ovf_b, k >= 4 ? 1 : 0);
    end
    chk("wide_count5", count_a, 5);
    chk("wide_ovf", ovf_a, 0);
    tick(0, 1); tick(0, 1);
    chk("sat_ovf_sticky", ovf_b, 1);

    // reset mid-pattern, with en and din=1 on the reset edge
    do_reset();
    tick(1, 1); tick(0, 1); tick(1, 1);
    reset = 1'b1;
    tick(1, 1);
    reset = 1'b0;
    chk("mid_rst_match", match_a, 0);
    chk("mid_rst_count", count_a, 0);
    tick(1, 1);
    chk("post_rst_nomatch", match_a, 0);
    tick(1, 1); tick(0, 1); tick(1, 1); tick(1, 1);
    chk("post_rst_match", match_a, 1);
    chk("post_rst_count", count_a, 1);

    // upstream flop feeding din
    do_reset();
    use_ms = 1'b1;
    ms_d = 1; tick(0, 1);
    ms_d = 0; tick(0, 1);
    ms_d = 1; tick(0, 1);
    ms_d = 1; tick(0, 1);
    chk("ms_q_final", ms_q, 1);
    chk("ms_early", match_a, 0);
    ms_d = 0; tick(0, 1);
    chk("ms_match", match_a, 1);
    chk("ms_count", count_a, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
